sum_hi_ctrl: RTL and testbench
==============================

// Module: sum_hi_ctrl
// PURPOSE
//  Sequences the combinational 121-tap weight-sum tree (14-bit weights -> 21-bit sum) for the bilateral filter.
//  Each pixel's normalisation sum arrives as NUM_PASS tree evaluations (one per colour plane / sub-window).
//  Per evaluation, drives the tree enable and hold value, and accumulates the passes into one wide sum.
//  Hands the sum downstream over valid/ready, and tracks pixel position and frame end.
// PARAMETERS
//  NUM_PASS       3     tree evaluations accumulated per pixel (>=1)
//  PIX_PER_FRAME  4096  pixels per frame; sets pix_idx wrap and frame_done
//  TREE_W         21    tree output width (fixed by 121 x 14-bit)
//  ACC_W          TREE_W+$clog2(NUM_PASS)  derived localparam; sized so the accumulator cannot overflow
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst         in   1       asynchronous reset, active-high
//  clr         in   1       sync abort: drop partial pixel, zero pix_idx
//  in_valid    in   1       upstream window weights present and stable at the tree inputs
//  in_ready    out  1       controller accepts the current tree evaluation this cycle
//  tree_en     out  1       to tree en; 1 only on an accepted beat
//  tree_sum    in   TREE_W  tree out_sum (combinational, same cycle as tree_en)
//  hold_sum    out  TREE_W  to tree reg_sum; last accepted tree_sum
//  out_valid   out  1       accumulated pixel sum available
//  out_ready   in   1       downstream accepts out_sum
//  out_sum     out  ACC_W   sum of NUM_PASS tree results for the pixel
//  pix_idx     out  PIX_W   index of the pixel in out_sum, 0..PIX_PER_FRAME-1 ($clog2)
//  frame_done  out  1       one-cycle pulse after the last pixel of the frame handshakes
// BEHAVIOUR
//  Reset: state=IDLE; acc, hold_sum, pass_cnt, pix_idx = 0; out_valid, frame_done, tree_en = 0.
//  Reset takes effect immediately, mid-pixel included; a partial pixel is lost and emits no output.
//  accept = in_valid & in_ready.  tree_en = accept (combinational); hold_sum <= tree_sum on accept.
//  in_ready = !clr & (state!=OUT | out_ready).
//  States:
//   IDLE: on accept: acc<=tree_sum, pass_cnt<=1; go to OUT if NUM_PASS==1, else ACC.
//   ACC:  on accept: acc<=acc+tree_sum (zero-extended), pass_cnt++.
//         When the beat with pass_cnt==NUM_PASS-1 is accepted, go to OUT.
//   OUT:  out_valid=1; out_sum=acc, stable until handshake.
//         On out_ready, pix_idx increments, wrapping PIX_PER_FRAME-1 -> 0.
//         frame_done pulses the cycle after the wrapping handshake.
//         If accept occurs in the same cycle, it starts the next pixel (IDLE rules), with no bubble.
//         Otherwise the block returns to IDLE.
//  Latency: out_valid rises 1 cycle after the final pass is accepted.
//  Throughput: 1 pixel per NUM_PASS cycles when in_valid and out_ready are held high.
//  Backpressure: out_ready=0 in OUT holds in_ready=0; tree_en stays 0, so the tree outputs hold_sum.
//  clr has priority over everything except rst. While clr=1, no beat is accepted.
//   Next cycle: state=IDLE, pass_cnt=0, pix_idx=0, out_valid=0; a pending out_sum is discarded.
//   acc and hold_sum keep their values.
//  in_valid falling mid-pixel: state and pass_cnt hold; the pixel resumes on the next accept.
//  Any in_valid before reset release is ignored.
// STRUCTURE
//  sum_hi_pkg: HI_W=14, TREE_W=21, TAPS=121, and the state enum {IDLE, ACC, OUT}.
//  Flat controller with no sub-module.
//  The parent instantiates the tree alongside, wiring tree_en->en, hold_sum->reg_sum, out_sum->tree_sum.
// TESTING
//  NUM_PASS=3, out_ready=1; tree_sum 100,200,300 on 3 consecutive accepts
//   -> out_sum=600, out_valid 1 cycle later, pix_idx=0.
//  Max values: tree_sum=1982343 x3 -> out_sum=5947029 (ACC_W=23), no wrap.
//  Continuous stream of 2 pixels, out_ready=1 -> outputs on cycles 4 and 7, no bubble, pix_idx 0 then 1.
//  out_ready=0 for 5 cycles in OUT with in_valid=1
//   -> in_ready=0, tree_en=0, out_sum stable; resumes the cycle out_ready rises.
//  clr asserted after 2 of 3 passes
//   -> no out_valid; the next 3 passes of 1,1,1 give out_sum=3, pix_idx=0.
//  PIX_PER_FRAME=4: 4 handshakes -> frame_done pulses once, pix_idx returns to 0.
//   rst mid-ACC -> all outputs 0 immediately.

Source files
------------

// File: rtl/sum_hi_pkg.sv
// Shared constants and state encoding for the bilateral-filter weight-sum controller.
// The tree width follows from the weight width and the tap count.
package sum_hi_pkg;

    localparam int HI_W   = 14;
    localparam int TAPS   = 121;
    localparam int TREE_W = HI_W + $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Wide enough that num_pass full-scale tree results cannot overflow.
    function automatic int acc_width(input int tree_w, input int num_pass);
        return tree_w + $clog2(num_pass);
    endfunction

endpackage

// File: rtl/sum_hi_ctrl.sv
// Sequences the weight-sum tree over NUM_PASS evaluations per pixel, accumulates them,
// and hands the pixel sum downstream with its position in the frame.
module sum_hi_ctrl #(
    parameter int NUM_PASS      = 3,
    parameter int PIX_PER_FRAME = 4096,
    parameter int TREE_W        = 21,
    localparam int ACC_W        = sum_hi_pkg::acc_width(TREE_W, NUM_PASS),
    localparam int PIX_W        = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tree_en,
    input  logic [TREE_W-1:0] tree_sum,
    output logic [TREE_W-1:0] hold_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [PIX_W-1:0]  pix_idx,
    output logic              frame_done
);
    import sum_hi_pkg::*;

    localparam int CNT_W = $clog2(NUM_PASS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PASS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_PER_FRAME - 1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TREE_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;
    logic              out_hs;

    // Gating with rst keeps the tree idle while the block is held in reset.
    assign in_ready   = !rst && !clr && ((state_q != OUT) || out_ready);
    assign accept     = in_valid && in_ready;
    assign tree_en    = accept;
    assign out_valid  = (state_q == OUT) && !clr;
    assign out_hs     = out_valid && out_ready;
    assign hold_sum   = hold_q;
    assign out_sum    = acc_q;
    assign pix_idx    = pix_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        hold_d       = hold_q;
        pass_d       = pass_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;

        if (accept) begin
            hold_d = tree_sum;
        end

        if (clr) begin
            state_d = IDLE;
            pass_d  = '0;
            pix_d   = '0;
        end else begin
            if (out_hs) begin
                pix_d        = (pix_q == LAST_PIX) ? '0 : pix_q + 1'b1;
                frame_done_d = (pix_q == LAST_PIX);
            end
            case (state_q)
                // A beat accepted while presenting a result starts the next pixel directly.
                IDLE, OUT: begin
                    if (accept) begin
                        acc_d   = ACC_W'(tree_sum);
                        pass_d  = CNT_W'(1);
                        state_d = (NUM_PASS == 1) ? OUT : ACC;
                    end else if ((state_q == OUT) && out_ready) begin
                        state_d = IDLE;
                        pass_d  = '0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d  = acc_q + ACC_W'(tree_sum);
                        pass_d = pass_q + 1'b1;
                        if (pass_q == LAST_CNT) begin
                            state_d = OUT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            hold_q       <= '0;
            pass_q       <= '0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            hold_q       <= hold_d;
            pass_q       <= pass_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sum_hi_ctrl.sv
// Scoreboard bench for sum_hi_ctrl: three passes per pixel, four pixels per frame.
module tb_sum_hi_ctrl;

    localparam int NP    = 3;
    localparam int PPF   = 4;
    localparam int ACC_W = 23;
    localparam int PIX_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic              tree_en;
    logic [20:0]       tree_sum;
    logic [20:0]       hold_sum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [PIX_W-1:0]  pix_idx;
    logic              frame_done;

    sum_hi_ctrl #(
        .NUM_PASS      (NP),
        .PIX_PER_FRAME (PPF),
        .TREE_W        (21)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tree_en    (tree_en),
        .tree_sum   (tree_sum),
        .hold_sum   (hold_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .pix_idx    (pix_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [PIX_W-1:0] idx;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [ACC_W-1:0] m_acc;
    int               m_pass;
    int               m_idx;
    int               checks = 0;
    int               errors = 0;
    int               frame_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted tree evaluation; the model predicts the pixel result on the final pass.
    task automatic beat(input logic [20:0] v);
        in_valid = 1'b1;
        tree_sum = v;
        @(negedge clk);
        check("tree_en", {31'd0, tree_en}, 32'd1);
        m_acc = (m_pass == 0) ? ACC_W'(v) : m_acc + ACC_W'(v);
        m_pass++;
        if (m_pass == NP) begin
            exp_q.push_back('{sum: m_acc, idx: PIX_W'(m_idx)});
            m_idx  = (m_idx + 1) % PPF;
            m_pass = 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("pixel idx=%0d sum=%0d (expected idx=%0d sum=%0d)",
                         pix_idx, out_sum, mon_e.idx, mon_e.sum);
                check("out_sum", 32'(out_sum), 32'(mon_e.sum));
                check("pix_idx", 32'(pix_idx), 32'(mon_e.idx));
            end
        end
        if (!rst && frame_done) begin
            frame_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tree_sum  = 21'd5;
        m_acc     = '0;
        m_pass    = 0;
        m_idx     = 0;

        // Reset with in_valid high: nothing accepted, all outputs zero.
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_tree_en", {31'd0, tree_en}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_hold_sum", 32'(hold_sum), 32'd0);
        check("rst_pix_idx", 32'(pix_idx), 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Basic pixel and one-cycle latency.
        beat(21'd100);
        beat(21'd200);
        beat(21'd300);
        @(negedge clk);
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        check("hold_sum_last", 32'(hold_sum), 32'd300);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Full-scale tree results.
        repeat (3) beat(21'd1982343);
        repeat (2) @(posedge clk);
        #1;

        // Two back-to-back pixels; tree_en on the overlap beat proves no bubble.
        beat(21'd10);
        beat(21'd20);
        beat(21'd30);
        beat(21'd40);
        beat(21'd50);
        beat(21'd60);
        repeat (3) @(negedge clk);
        check("frame_done_count", 32'(frame_cnt), 32'd1);
        check("pix_idx_wrapped", 32'(pix_idx), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure in OUT with the next beat waiting.
        beat(21'd7);
        beat(21'd8);
        beat(21'd9);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tree_sum  = 21'd11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_tree_en", {31'd0, tree_en}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_sum", 32'(out_sum), 32'd24);
            check("stall_hold_sum", 32'(hold_sum), 32'd9);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        beat(21'd11);
        beat(21'd12);
        beat(21'd13);
        repeat (2) @(posedge clk);
        #1;

        // Abort after two passes: partial pixel dropped, index back to zero.
        beat(21'd5);
        beat(21'd6);
        clr      = 1'b1;
        in_valid = 1'b1;
        tree_sum = 21'd99;
        @(negedge clk);
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        check("clr_tree_en", {31'd0, tree_en}, 32'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        m_pass   = 0;
        m_idx    = 0;
        @(negedge clk);
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_pix_idx", 32'(pix_idx), 32'd0);
        check("clr_hold_sum", 32'(hold_sum), 32'd6);
        @(posedge clk);
        #1;
        repeat (3) beat(21'd1);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-accumulation takes effect before the next edge.
        beat(21'd7);
        beat(21'd8);
        in_valid = 1'b1;
        tree_sum = 21'd4;
        #2;
        rst = 1'b1;
        #1;
        check("arst_tree_en", {31'd0, tree_en}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_sum", 32'(out_sum), 32'd0);
        check("arst_hold_sum", 32'(hold_sum), 32'd0);
        check("arst_pix_idx", 32'(pix_idx), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        m_pass   = 0;
        m_idx    = 0;
        @(posedge clk);
        #1;
        beat(21'd1);
        beat(21'd2);
        beat(21'd3);
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
